// File: rtl/port_uart_transmitter_pkg.sv
// Shared types and status-word bit positions for the UART transmitter port.
// Software headers mirror the STATUS_* constants to decode statusWord.
package JZJCoreFTypes;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } UARTTxState_t;

   localparam int STATUS_ACK_BIT       = 0;
   localparam int STATUS_FULL_BIT      = 1;
   localparam int STATUS_EMPTY_BIT     = 2;
   localparam int STATUS_BUSY_BIT      = 3;
   localparam int STATUS_COUNT_LSB     = 4;
   localparam int STATUS_COUNT_MSB     = 8;

   localparam int CMD_DATA_MSB         = 7;
   localparam int CMD_TOGGLE_BIT       = 8;

endpackage

// File: rtl/port_uart_transmitter_fifo.sv
// Byte FIFO feeding the serializer. Power-of-two depth so the pointers wrap
// naturally; push into a full FIFO and pop from an empty one are ignored.
module PortUARTTransmitterFIFO #(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [7:0]                 dataIn,
   output logic [7:0]                 dataOut,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign full      = (r_count == CW'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;
   assign dataOut   = r_mem[r_rd_ptr];
   assign count     = r_count;

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= dataIn;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/port_uart_transmitter.sv
// UART transmitter behind a CPU memory-mapped port pair.
// A new byte is requested by flipping commandWord[8]; the port echoes the
// toggle on statusWord[0] once the byte is accepted into the FIFO.
//
// state | meaning
// IDLE  | line high; dequeue next byte as soon as FIFO is non-empty
// START | start bit (txd=0) for CLOCKS_PER_BIT cycles
// DATA  | 8 data bits LSB first, CLOCKS_PER_BIT cycles each
// STOP  | stop bit (txd=1) for CLOCKS_PER_BIT cycles, then back to IDLE
module port_uart_transmitter
   import JZJCoreFTypes::*;
#(
   parameter int CLOCKS_PER_BIT = 434,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] commandWord,
   output logic [31:0] statusWord,
   output logic        txd
);

   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0]   BAUD_LAST = 16'(CLOCKS_PER_BIT - 1);

   UARTTxState_t  r_state;
   logic          r_txd;
   logic [15:0]   r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_last_toggle;
   logic          r_ack;

   logic          w_req;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic          w_baud_last;
   logic [7:0]    w_fifo_dout;
   logic [CW-1:0] w_fifo_count;
   logic [4:0]    w_count5;
   logic          w_unused;

   // Upper command bits carry nothing for this port.
   assign w_unused    = ^commandWord[31:9];

   // Full comes from the registered count, so a full FIFO refuses the push
   // even on the edge where the serializer pops; the request simply stays
   // pending because lastToggle is left alone.
   assign w_req       = (commandWord[CMD_TOGGLE_BIT] != r_last_toggle);
   assign w_push      = w_req & ~w_full;
   assign w_pop       = (r_state == IDLE) & ~w_empty;
   assign w_baud_last = (r_baud == BAUD_LAST);
   assign w_busy      = (r_state != IDLE);
   assign w_count5    = 5'(w_fifo_count);

   PortUARTTransmitterFIFO #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (w_push),
      .pop     (w_pop),
      .dataIn  (commandWord[CMD_DATA_MSB:0]),
      .dataOut (w_fifo_dout),
      .count   (w_fifo_count),
      .full    (w_full),
      .empty   (w_empty)
   );

   // Request handshake: accept the byte and echo the toggle on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_toggle <= 1'b0;
         r_ack         <= 1'b0;
      end else if (w_push) begin
         r_last_toggle <= commandWord[CMD_TOGGLE_BIT];
         r_ack         <= commandWord[CMD_TOGGLE_BIT];
      end
   end

   // Serializer FSM with registered line output.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_txd   <= 1'b1;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_txd  <= 1'b1;
               r_baud <= '0;
               r_bit  <= '0;
               if (w_pop) begin
                  r_shift <= w_fifo_dout;
                  r_txd   <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_txd   <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
                  r_state <= DATA;
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            DATA: begin
               if (w_baud_last) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_bit   <= '0;
                     r_txd   <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_txd   <= r_shift[0];
                     r_shift <= {1'b0, r_shift[7:1]};
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            STOP: begin
               r_txd <= 1'b1;
               if (w_baud_last) begin
                  r_baud  <= '0;
                  r_state <= IDLE;
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_txd   <= 1'b1;
               r_baud  <= '0;
               r_bit   <= '0;
            end
         endcase
      end
   end

   assign txd = r_txd;

   always_comb begin
      statusWord                                      = '0;
      statusWord[STATUS_ACK_BIT]                      = r_ack;
      statusWord[STATUS_FULL_BIT]                     = w_full;
      statusWord[STATUS_EMPTY_BIT]                    = w_empty;
      statusWord[STATUS_BUSY_BIT]                     = w_busy;
      statusWord[STATUS_COUNT_MSB:STATUS_COUNT_LSB]   = w_count5;
   end

endmodule

// File: tb/tb_port_uart_transmitter.sv
// Bench for port_uart_transmitter: CLOCKS_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes every frame from txd and compares it with a queue
// of bytes pushed when each write was issued.
module tb_port_uart_transmitter;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] commandWord = '0;
   logic [31:0] statusWord;
   logic        txd;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  sb [$];
   logic        r_tog = 1'b0;
   logic        mon_en = 1'b1;

   int          m_pos = 0;
   int          m_gap = 0;
   int          last_gap = 0;
   int          n_frames = 0;
   logic        m_active = 1'b0;
   logic        m_bad = 1'b0;
   logic [7:0]  m_byte = '0;

   port_uart_transmitter #(
      .CLOCKS_PER_BIT (CPB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .commandWord (commandWord),
      .statusWord  (statusWord),
      .txd         (txd)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Frame decoder: every sample of a slot must match the slot's first sample.
   always @(negedge clock) begin
      if (!mon_en || reset) begin
         m_active = 1'b0;
         m_gap    = 0;
      end else begin
         if (!m_active) begin
            if (txd == 1'b0) begin
               m_active = 1'b1;
               m_pos    = 0;
               m_bad    = 1'b0;
               m_byte   = '0;
               last_gap = m_gap;
            end else if (m_gap < 100000) begin
               m_gap++;
            end
         end
         if (m_active) begin
            int slot;
            slot = m_pos / CPB;
            if (slot == 0) begin
               if (txd !== 1'b0) m_bad = 1'b1;
            end else if (slot == 9) begin
               if (txd !== 1'b1) m_bad = 1'b1;
            end else if ((m_pos % CPB) == 0) begin
               m_byte[slot-1] = txd;
            end else if (txd !== m_byte[slot-1]) begin
               m_bad = 1'b1;
            end
            m_pos++;
            if (m_pos == FRAME) begin
               chk("frame_shape", {31'd0, m_bad}, 32'd0);
               if (sb.size() == 0) begin
                  chk("frame_unexpected", {24'd0, m_byte}, 32'hFFFF_FFFF);
               end else begin
                  logic [7:0] exp_b;
                  exp_b = sb.pop_front();
                  chk("frame_byte", {24'd0, m_byte}, {24'd0, exp_b});
               end
               n_frames++;
               m_active = 1'b0;
               m_gap    = 0;
            end
         end
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic write_byte(input logic [7:0] b, output int waited);
      r_tog = ~r_tog;
      commandWord = {23'd0, r_tog, b};
      sb.push_back(b);
      waited = 0;
      do begin
         @(negedge clock);
         waited++;
      end while (statusWord[0] !== r_tog && waited < 500);
      chk("ack_seen", {31'd0, statusWord[0]}, {31'd0, r_tog});
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(statusWord[2] === 1'b1 && statusWord[3] === 1'b0) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk(tag, {31'd0, (n < 3000)}, 32'd1);
      cycles(2);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      int prev_cnt;
      int frames_before;
      int bad_idle;

      // Reset state
      cycles(3);
      reset = 1'b0;
      chk("reset_status", statusWord, 32'h4);
      chk("reset_txd", {31'd0, txd}, 32'd1);

      // Single byte 0x55: ack one cycle later, start bit the cycle after
      write_byte(8'h55, w);
      chk("ack_latency", w, 1);
      chk("txd_before_start", {31'd0, txd}, 32'd1);
      @(negedge clock);
      chk("txd_start_fall", {31'd0, txd}, 32'd0);
      chk("busy_in_start", {31'd0, statusWord[3]}, 32'd1);
      wait_idle("idle_after_55");
      chk("frames_after_55", n_frames, 1);

      // Data change without toggle is ignored
      commandWord[7:0] = 8'hEE;
      cycles(4);
      chk("no_toggle_status", statusWord, {31'd0, r_tog} | 32'h4);
      chk("no_toggle_frames", n_frames, 1);

      // Fill the FIFO while 0x01 is shifting
      for (int i = 1; i <= 5; i++) begin
         write_byte(8'(i), w);
         chk("fill_ack_latency", w, 1);
      end
      chk("full_flag", {31'd0, statusWord[1]}, 32'd1);
      chk("full_count", {27'd0, statusWord[8:4]}, 32'd4);
      chk("full_busy", {31'd0, statusWord[3]}, 32'd1);

      // Request while full: held until the serializer dequeues
      r_tog = ~r_tog;
      commandWord = {23'd0, r_tog, 8'h06};
      sb.push_back(8'h06);
      w = 0;
      prev_cnt = 4;
      do begin
         prev_cnt = statusWord[8:4];
         @(negedge clock);
         w++;
      end while (statusWord[0] !== r_tog && w < 500);
      chk("held_ack_seen", {31'd0, statusWord[0]}, {31'd0, r_tog});
      chk("held_ack_withheld", {31'd0, (w > 20)}, 32'd1);
      chk("held_count_before_ack", prev_cnt, 3);
      chk("held_count_at_ack", {27'd0, statusWord[8:4]}, 32'd4);
      wait_idle("idle_after_fill");
      chk("fill_gap", last_gap, 1);
      chk("frames_after_fill", n_frames, 7);

      // Two queued bytes go out back to back with one idle cycle
      write_byte(8'hA5, w);
      write_byte(8'h3C, w);
      chk("second_ack_latency", w, 1);
      wait_idle("idle_after_pair");
      chk("pair_gap", last_gap, 1);
      chk("frames_after_pair", n_frames, 9);

      // Toggle held high through reset enqueues once afterwards
      reset = 1'b1;
      r_tog = 1'b1;
      commandWord = {23'd0, 1'b1, 8'h5A};
      cycles(2);
      chk("reset_hold_status", statusWord, 32'h4);
      sb.push_back(8'h5A);
      reset = 1'b0;
      @(negedge clock);
      chk("post_reset_ack", {31'd0, statusWord[0]}, 32'd1);
      wait_idle("idle_after_5a");
      cycles(10);
      chk("post_reset_status", statusWord, 32'h5);
      chk("frames_after_5a", n_frames, 10);

      // Reset in the middle of data bit 3 aborts the frame
      write_byte(8'hC3, w);
      cycles(18);
      chk("txd_bit3", {31'd0, txd}, 32'd0);
      chk("busy_bit3", {31'd0, statusWord[3]}, 32'd1);
      mon_en = 1'b0;
      void'(sb.pop_back());
      reset = 1'b1;
      r_tog = 1'b0;
      commandWord = '0;
      @(negedge clock);
      chk("abort_txd", {31'd0, txd}, 32'd1);
      chk("abort_status", statusWord, 32'h4);
      reset = 1'b0;
      mon_en = 1'b1;
      frames_before = n_frames;
      bad_idle = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (txd !== 1'b1 || statusWord !== 32'h4) bad_idle++;
      end
      chk("abort_stays_idle", bad_idle, 0);
      chk("abort_no_frame", n_frames, frames_before);
      chk("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
